// File: rtl/binary_spike_encoder_if.sv
// Request channel of the spike encoder: valid/ready handshake carrying
// the intensity fraction and the number of timesteps to emit.
interface binary_spike_encoder_if #(
    parameter int FRACTION_BITS = 8,
    parameter int STEP_WIDTH    = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [FRACTION_BITS-1:0] in_value;
    logic [STEP_WIDTH-1:0]    in_steps;

    modport master (output in_valid, output in_value, output in_steps, input in_ready);
    modport slave  (input in_valid, input in_value, input in_steps, output in_ready);
endinterface

// File: rtl/binary_spike_encoder.sv
// First-order sigma-delta rate encoder: emits floor(N*value/2^FRACTION_BITS)
// spikes on I over N timesteps, then pulses done with the spike count.
module binary_spike_encoder #(
    parameter int FRACTION_BITS = 8,
    parameter int STEP_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    binary_spike_encoder_if.slave req,
    output logic                  I,
    output logic                  busy,
    output logic                  done,
    output logic [STEP_WIDTH-1:0] spike_count
);

    typedef enum logic [1:0] {IDLE, ENCODE, FINISH} state_t;

    state_t                   state, state_next;
    logic [FRACTION_BITS:0]   acc;
    logic [FRACTION_BITS:0]   sum;
    logic [FRACTION_BITS-1:0] val;
    logic [STEP_WIDTH-1:0]    remaining;
    logic [STEP_WIDTH-1:0]    count;
    logic                     accept;
    logic                     carry;

    assign req.in_ready = (state == IDLE) && reset;
    assign accept       = req.in_valid && req.in_ready;
    assign busy         = (state != IDLE);
    assign sum          = acc + {1'b0, val};
    assign carry        = sum[FRACTION_BITS];

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (req.in_steps != '0) ? ENCODE : FINISH;
            ENCODE:  if (remaining == STEP_WIDTH'(1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            I           <= 1'b0;
            done        <= 1'b0;
            spike_count <= '0;
            acc         <= '0;
            count       <= '0;
            remaining   <= '0;
            val         <= '0;
        end else begin
            I    <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        val       <= req.in_value;
                        remaining <= req.in_steps;
                        acc       <= '0;
                        count     <= '0;
                    end
                end
                ENCODE: begin
                    // The carry out of the accumulator is the spike for this step.
                    I         <= carry;
                    acc       <= {1'b0, sum[FRACTION_BITS-1:0]};
                    count     <= count + STEP_WIDTH'(carry);
                    remaining <= remaining - STEP_WIDTH'(1);
                end
                FINISH: begin
                    done        <= 1'b1;
                    spike_count <= count;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_spike_encoder.sv
// Directed plus randomized checks of binary_spike_encoder against a closed-form
// rate model: spike at step j = floor(j*v/2^F) - floor((j-1)*v/2^F).
module tb_binary_spike_encoder;
    localparam int FB  = 8;
    localparam int SW  = 8;
    localparam int ONE = 1 << FB;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          I, busy, done;
    logic [SW-1:0] spike_count;
    int            compared = 0;
    int            mismatched = 0;

    always #5 clk = ~clk;

    binary_spike_encoder_if #(.FRACTION_BITS(FB), .STEP_WIDTH(SW)) bus ();

    binary_spike_encoder #(.FRACTION_BITS(FB), .STEP_WIDTH(SW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (bus),
        .I           (I),
        .busy        (busy),
        .done        (done),
        .spike_count (spike_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_spike(input int v, input int j);
        return ((j * v) / ONE) - (((j - 1) * v) / ONE);
    endfunction

    // Issue one request and follow it to its done pulse. With arm set, the
    // next request is driven valid during FINISH so it lands in the done cycle.
    task automatic run_request(input int v, input int n, input bit arm = 1'b0,
                               input int nv = 0, input int nn = 0);
        int total;
        total = (n * v) / ONE;
        check("ready_before_accept", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_value = v[FB-1:0];
        bus.in_steps = n[SW-1:0];
        tick;
        bus.in_valid = 1'b0;
        check("busy_after_accept", busy, 1);
        for (int j = 1; j <= n; j++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_value = FB'($urandom);
            bus.in_steps = SW'($urandom);
            tick;
            check($sformatf("spike v=%0d n=%0d step=%0d", v, n, j), I, model_spike(v, j));
            check("done_low_during_encode", done, 0);
            check("busy_during_encode", busy, 1);
        end
        if (arm) begin
            bus.in_valid = 1'b1;
            bus.in_value = nv[FB-1:0];
            bus.in_steps = nn[SW-1:0];
        end else begin
            bus.in_valid = 1'b0;
            bus.in_value = FB'($urandom);
        end
        check("ready_low_in_finish", bus.in_ready, 0);
        tick;
        check("done_pulse", done, 1);
        check($sformatf("spike_count v=%0d n=%0d", v, n), spike_count, total);
        check("I_low_after_finish", I, 0);
        check("busy_low_in_done_cycle", busy, 0);
        check("ready_in_done_cycle", bus.in_ready, 1);
        if (!arm) begin
            tick;
            check("done_cleared", done, 0);
            check("spike_count_held", spike_count, total);
            check("I_idle", I, 0);
        end
    endtask

    initial begin
        bus.in_valid = 1'b1;
        bus.in_value = 8'd128;
        bus.in_steps = 8'd5;

        repeat (3) begin
            tick;
            check("rst_I", I, 0);
            check("rst_done", done, 0);
            check("rst_spike_count", spike_count, 0);
            check("rst_in_ready", bus.in_ready, 0);
            check("rst_busy", busy, 0);
        end
        bus.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("ready_after_release", bus.in_ready, 1);
        tick;
        check("idle_after_release", busy, 0);

        run_request(128, 20);
        run_request(230, 20);
        run_request(255, 255);
        run_request(0, 10);
        run_request(0, 0);

        // Back-to-back: second request held valid from the first one's FINISH.
        run_request(100, 12, 1'b1, 64, 8);
        run_request(64, 8);

        // Abort mid-encode at E5.
        bus.in_valid = 1'b1;
        bus.in_value = 8'd128;
        bus.in_steps = 8'd20;
        tick;
        bus.in_valid = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            tick;
            check("pre_abort_spike", I, model_spike(128, j));
        end
        reset = 1'b0;
        tick;
        check("abort_I", I, 0);
        check("abort_done", done, 0);
        check("abort_spike_count", spike_count, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", bus.in_ready, 0);
        reset = 1'b1;
        #1;
        check("abort_ready_release", bus.in_ready, 1);
        for (int k = 0; k < 24; k++) begin
            tick;
            check("no_done_after_abort", done, 0);
            check("abort_count_held", spike_count, 0);
        end
        run_request(128, 20);

        for (int r = 0; r < 8; r++) begin
            run_request(int'($urandom_range(0, 255)), int'($urandom_range(0, 40)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/binary_spike_encoder.md
# binary_spike_encoder

Rate encoder that turns a multi-bit intensity into a binary spike train on `I`, one timestep per clock. It drives the binary input of `binary_lif_neuron` and is the transmit end of the neuron's 1-bit spike input. It uses a first-order sigma-delta accumulator in the same fixed-point convention as the neuron, so the intensity is a fraction of `2^FRACTION_BITS`. Each encode request is accepted with a valid/ready handshake and closes with a done pulse that reports how many spikes were sent.

## Interface
- `FRACTION_BITS`, 8, intensity width; rate = `in_value / 2^FRACTION_BITS` spikes per step
- `STEP_WIDTH`, 8, width of the step counter and of `spike_count`
- `clk`  input  1  rising-edge clock
- `reset`  input  1  synchronous, active-low reset
- `in_valid`  input  1  request valid
- `in_ready`  output  1  encoder can accept a request
- `in_value`  input  FRACTION_BITS  intensity, unsigned fraction
- `in_steps`  input  STEP_WIDTH  number of timesteps N to emit; 0 is legal
- `I`  output  1  registered spike output, one timestep per cycle
- `busy`  output  1  state != IDLE
- `done`  output  1  one-cycle pulse at end of a request
- `spike_count`  output  STEP_WIDTH  spikes emitted by the last completed request; held until the next `done`

## Operation
- States: IDLE, ENCODE, FINISH.
- `in_ready` = (state == IDLE) and `reset` high. It is 0 while `reset` is low.
- Accept: at a rising edge with `in_valid && in_ready`:
  - latch `in_value` into `val` and `in_steps` into `remaining`
  - clear `acc` (FRACTION_BITS+1 bits) and the internal `count`
  - go to ENCODE if N>0, else go to FINISH
- ENCODE, every edge:
  - `sum = acc + val`, computed at FRACTION_BITS+1 bits
  - `I <= sum[FRACTION_BITS]` (the carry)
  - `acc <= {1'b0, sum[FRACTION_BITS-1:0]}`
  - `count <= count + carry`
  - `remaining <= remaining - 1`
  - when `remaining == 1` at that edge, go to FINISH
- FINISH, one edge: `I <= 0`, `done <= 1`, `spike_count <= count`, go to IDLE.
- `done` clears at the next edge.
- Total spikes over N steps = floor(N·in_value / 2^FRACTION_BITS). The first spike falls at the first step where the accumulated sum reaches 2^FRACTION_BITS.
- `count` never overflows: count ≤ N ≤ 2^STEP_WIDTH−1.
- `in_value` = 0 gives no spikes. The maximum value (2^FRACTION_BITS−1) gives N−1 spikes for N ≤ 2^FRACTION_BITS, so a rate of 1.0 is unreachable by design.
- Changes on `in_value` and `in_steps` after acceptance are ignored. `in_valid` is ignored outside IDLE.
- Reset low at any edge, including mid-ENCODE:
  - state goes to IDLE
  - `I`, `done`, `spike_count`, `acc`, `count` and `remaining` are cleared
  - no `done` is produced for the aborted request

## Timing
- Reset values: `I`=0, `done`=0, `spike_count`=0, `busy`=0, `in_ready`=0 while reset is held, 1 after release.
- Edge numbering: E0 is the accept edge.
- Step j spike (j=1..N) is written at edge Ej and is visible during the cycle after Ej. The neuron samples it at Ej+1.
- N>0: FINISH is entered at EN. `done`=1 and `spike_count` update during the cycle after E(N+1).
- N=0: `done`=1 during the cycle after E1. `I` stays 0.
- `in_ready` is 1 during the `done` cycle, so a back-to-back request is accepted at E(N+2). That gives one idle timestep with `I`=0 between trains.
- `busy` is 1 from the cycle after E0 through the cycle after EN.

## Test plan
- Reset held low 3 cycles with `in_valid`=1 → `I`=0, `done`=0, `spike_count`=0, `in_ready`=0, no request accepted. After release, `in_ready`=1.
- `in_value`=128, `in_steps`=20 → `I` = 0,1,0,1,… over steps 1–20 (10 spikes). `done` pulses one cycle after E21. `spike_count`=10. `I`=0 after E21.
- `in_value`=230, `in_steps`=20 → 17 spikes, first at step 2, `spike_count`=17. Then `in_value`=255, `in_steps`=255 → `spike_count`=254.
- `in_value`=0, `in_steps`=10 → `I` constant 0, `spike_count`=0. Then `in_steps`=0 → `done` in the cycle after E1, `spike_count`=0, `busy` high for exactly one cycle.
- Back-to-back: second request (`in_value`=64, `in_steps`=8) held valid from the first request's FINISH → accepted in the `done` cycle, yields 2 spikes (steps 4, 8). Toggling `in_value` mid-encode has no effect.
- Reset low at E5 of a `in_value`=128, N=20 request → `I`=0 after that edge, no `done`, `spike_count` stays 0. A new request after release encodes normally from `acc`=0.
